// File: rtl/bus8_arb_pkg.sv
// Shared types and defaults for the 8-bit bus round-robin arbiter.
package bus8_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_W        = 8;
    localparam int unsigned DEF_MAXBURST = 8;

    // Wide enough for MAXBURST-1 at the largest allowed MAXBURST (255).
    localparam int unsigned CNT_W = 8;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus8_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, cyclically.
module rr_pick
    import bus8_arb_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   win,
    output logic            any_req
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus8_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit output bus among NREQ requesters,
// with bounded bursts and one idle turnaround cycle between grants.
module bus8_rr_arbiter
    import bus8_arb_pkg::*;
#(
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned W        = DEF_W,
    parameter int unsigned MAXBURST = DEF_MAXBURST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] D,
    output logic [NREQ-1:0]   GNT,
    output logic [W-1:0]      O,
    output logic              OE,
    output logic              BUSY
);

    localparam int unsigned         PW       = idx_w(NREQ);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAXBURST - 1);
    localparam logic [PW-1:0]       PTR_LAST = PW'(NREQ - 1);

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [PW-1:0]     gidx, gidx_n;
    logic [PW-1:0]     win;
    logic              any_req;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NREQ-1:0]   gnt_q, gnt_n;
    logic [W-1:0]      o_q, o_n;
    logic              oe_q, oe_n;
    logic              busy_q;
    logic              stay;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (REQ),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );

    assign stay = REQ[gidx] && (cnt < CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gidx   <= '0;
            cnt    <= '0;
            gnt_q  <= '0;
            o_q    <= '0;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gidx   <= gidx_n;
            cnt    <= cnt_n;
            gnt_q  <= gnt_n;
            o_q    <= o_n;
            oe_q   <= oe_n;
            busy_q <= (state_n != ST_IDLE);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE, ST_GAP: state_n = any_req ? ST_GRANT : ST_IDLE;
            ST_GRANT:        state_n = stay ? ST_GRANT : ST_GAP;
            default:         state_n = ST_IDLE;
        endcase
    end

    // Registered outputs default to the bus-released values; only an active
    // or starting grant drives them.
    always_comb begin
        gnt_n  = '0;
        o_n    = '0;
        oe_n   = 1'b0;
        cnt_n  = cnt;
        ptr_n  = ptr;
        gidx_n = gidx;
        unique case (state)
            ST_IDLE, ST_GAP: begin
                if (any_req) begin
                    gnt_n[win] = 1'b1;
                    o_n        = D[32'(win)*W +: W];
                    oe_n       = 1'b1;
                    cnt_n      = '0;
                    gidx_n     = win;
                end
            end
            ST_GRANT: begin
                if (stay) begin
                    gnt_n = gnt_q;
                    o_n   = D[32'(gidx)*W +: W];
                    oe_n  = 1'b1;
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    ptr_n = (gidx == PTR_LAST) ? '0 : gidx + PW'(1);
                end
            end
            default: ;
        endcase
    end

    assign GNT  = gnt_q;
    assign O    = o_q;
    assign OE   = oe_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_bus8_rr_arbiter.sv
// Directed bench for bus8_rr_arbiter at MAXBURST=8 and MAXBURST=1.
module tb_bus8_rr_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = '0;
    logic [31:0] D   = '0;

    logic [3:0] gnt8, gnt1;
    logic [7:0] o8, o1;
    logic       oe8, oe1, busy8, busy1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bus8_rr_arbiter #(.NREQ(4), .W(8), .MAXBURST(8)) dut8 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
        .GNT(gnt8), .O(o8), .OE(oe8), .BUSY(busy8)
    );

    bus8_rr_arbiter #(.NREQ(4), .W(8), .MAXBURST(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
        .GNT(gnt1), .O(o1), .OE(oe1), .BUSY(busy1)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b1111;
        D   = 32'h44332211;
        repeat (3) begin
            step();
            checks++;
            if (gnt8 !== 4'b0000 || o8 !== 8'h00 || oe8 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: gnt=%b o=%h oe=%b busy=%b, expected 0000 00 0 0",
                         gnt8, o8, oe8, busy8);
            end
        end
        RST = 1'b0;
        step();
        checks++;
        if (gnt8 !== 4'b0001 || o8 !== 8'h11 || oe8 !== 1'b1 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: gnt=%b o=%h oe=%b busy=%b, expected 0001 11 1 1",
                     gnt8, o8, oe8, busy8);
        end
    endtask

    task automatic test_single_burst();
        logic [7:0] words [3];
        words = '{8'hA5, 8'h5A, 8'h3C};
        do_reset();
        D   = '0;
        REQ = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            D[23:16] = words[i];
            step();
            checks++;
            if (gnt8 !== 4'b0100 || o8 !== words[i] || oe8 !== 1'b1 || busy8 !== 1'b1) begin
                failures++;
                $display("FAIL burst_word%0d: gnt=%b o=%h oe=%b busy=%b, expected 0100 %h 1 1",
                         i, gnt8, o8, oe8, busy8, words[i]);
            end
        end
        REQ = 4'b0000;
        step();
        checks++;
        if (gnt8 !== 4'b0000 || o8 !== 8'h00 || oe8 !== 1'b0 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL burst_gap: gnt=%b o=%h oe=%b busy=%b, expected 0000 00 0 1",
                     gnt8, o8, oe8, busy8);
        end
        step();
        checks++;
        if (gnt8 !== 4'b0000 || oe8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle: gnt=%b oe=%b busy=%b, expected 0000 0 0",
                     gnt8, oe8, busy8);
        end
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [3:0] eg;
        logic [7:0] eo;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        D   = 32'h44332211;
        REQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            eg = 4'b0001 << order[n];
            eo = 8'(8'h11 * (order[n] + 1));
            for (int c = 0; c < 8; c++) begin
                step();
                checks++;
                if (gnt8 !== eg || o8 !== eo || oe8 !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_grant%0d_cyc%0d: gnt=%b o=%h oe=%b, expected %b %h 1",
                             n, c, gnt8, o8, oe8, eg, eo);
                end
            end
            step();
            checks++;
            if (gnt8 !== 4'b0000 || o8 !== 8'h00 || oe8 !== 1'b0 || busy8 !== 1'b1) begin
                failures++;
                $display("FAIL rr_gap%0d: gnt=%b o=%h oe=%b busy=%b, expected 0000 00 0 1",
                         n, gnt8, o8, oe8, busy8);
            end
        end
    endtask

    task automatic test_maxburst1();
        logic [3:0] seq [6];
        seq = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
        do_reset();
        D   = 32'h44332211;
        REQ = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (gnt1 !== seq[i] || oe1 !== (|seq[i]) || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL mb1_cyc%0d: gnt=%b oe=%b busy=%b, expected %b %b 1",
                         i, gnt1, oe1, busy1, seq[i], |seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        D   = 32'h44332211;
        REQ = 4'b0010;
        repeat (4) step();
        checks++;
        if (gnt8 !== 4'b0010 || o8 !== 8'h22 || oe8 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: gnt=%b o=%h oe=%b, expected 0010 22 1", gnt8, o8, oe8);
        end
        RST = 1'b1;
        step();
        checks++;
        if (gnt8 !== 4'b0000 || o8 !== 8'h00 || oe8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: gnt=%b o=%h oe=%b busy=%b, expected 0000 00 0 0",
                     gnt8, o8, oe8, busy8);
        end
        RST = 1'b0;
        step();
        checks++;
        if (gnt8 !== 4'b0010 || o8 !== 8'h22 || oe8 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_regrant: gnt=%b o=%h oe=%b, expected 0010 22 1", gnt8, o8, oe8);
        end
    endtask

    task automatic test_wrap_no_preempt();
        do_reset();
        D   = 32'h44332211;
        REQ = 4'b1000;
        step();
        checks++;
        if (gnt8 !== 4'b1000 || o8 !== 8'h44) begin
            failures++;
            $display("FAIL np_first: gnt=%b o=%h, expected 1000 44", gnt8, o8);
        end
        REQ = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt8 !== 4'b1000 || o8 !== 8'h44 || oe8 !== 1'b1) begin
                failures++;
                $display("FAIL np_hold%0d: gnt=%b o=%h oe=%b, expected 1000 44 1",
                         i, gnt8, o8, oe8);
            end
        end
        REQ = 4'b0001;
        step();
        checks++;
        if (gnt8 !== 4'b0000 || oe8 !== 1'b0 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL np_gap: gnt=%b oe=%b busy=%b, expected 0000 0 1", gnt8, oe8, busy8);
        end
        step();
        checks++;
        if (gnt8 !== 4'b0001 || o8 !== 8'h11 || oe8 !== 1'b1) begin
            failures++;
            $display("FAIL np_next: gnt=%b o=%h oe=%b, expected 0001 11 1", gnt8, o8, oe8);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_maxburst1();
        test_reset_mid_grant();
        test_wrap_no_preempt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
